// File: rtl/codiq_sequencer_if.sv
// Chip FIFO read port plus IQ coder / DAC handshake seen by codiq_sequencer.
// master = sequencer side, slave = FIFO/coder/DAC side.
interface codiq_sequencer_if;
  logic chip_data;
  logic chip_valid;
  logic chip_rd;
  logic coder_ready;
  logic dac_ready;
  logic b_in;
  logic en_2MHz;
  logic mem_state;

  modport master (
    input  chip_data, chip_valid, coder_ready, dac_ready,
    output chip_rd, b_in, en_2MHz, mem_state
  );

  modport slave (
    output chip_data, chip_valid, coder_ready, dac_ready,
    input  chip_rd, b_in, en_2MHz, mem_state
  );
endinterface

// File: rtl/codiq_sequencer.sv
// Frame sequencer pacing FIFO chips into the O-QPSK IQ coder at the 2 MHz chip rate.
// Define CODIQ_SEQ_STATUS_EN to add the chip_cnt / stall_cnt status outputs.
module codiq_sequencer #(
  parameter int CHIP_DIV    = 25,
  parameter int EN_HIGH     = 13,
  parameter int TAIL_CYCLES = 50,
  parameter int LEN_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] nb_chips,
  codiq_sequencer_if.master chip_if,
  output logic             busy,
  output logic             done,
  output logic             underrun
`ifdef CODIQ_SEQ_STATUS_EN
  ,
  output logic [LEN_W-1:0] chip_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_RDY = 2'd1;
  localparam logic [1:0] CHIP     = 2'd2;
  localparam logic [1:0] TAIL     = 2'd3;

  localparam int DIV_W  = $clog2(CHIP_DIV + 1);
  localparam int TAIL_W = $clog2(TAIL_CYCLES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CHIP_DIV - 1);
  localparam logic [DIV_W-1:0]  EN_LIM    = DIV_W'(EN_HIGH);
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_CYCLES - 1);

  logic [1:0]        state;
  logic [LEN_W-1:0]  remaining;
  logic [DIV_W-1:0]  div_cnt;
  logic [TAIL_W-1:0] tail_cnt;

  logic accept;
  logic at_boundary;
  logic last_chip;
  logic take_first;
  logic take_next;
  logic starved;
  logic [DIV_W-1:0] div_nxt;

  assign accept      = (state == IDLE) && start && (nb_chips != '0);
  assign at_boundary = (state == CHIP) && chip_if.dac_ready && (div_cnt == DIV_LAST);
  assign last_chip   = (remaining == LEN_W'(1));
  assign take_first  = (state == WAIT_RDY) && chip_if.coder_ready &&
                       chip_if.dac_ready && chip_if.chip_valid;
  assign take_next   = at_boundary && !last_chip && chip_if.chip_valid;
  assign starved     = at_boundary && !last_chip && !chip_if.chip_valid;
  assign div_nxt     = div_cnt + DIV_W'(1);

  // The pop is combinational so the FIFO head is consumed in the same cycle it is sampled.
  assign chip_if.chip_rd = !reset && (take_first || take_next);
  assign busy            = (state != IDLE);

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see pre-edge values; blocking assignments would create order-dependent logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      remaining         <= '0;
      div_cnt           <= '0;
      tail_cnt          <= '0;
      chip_if.b_in      <= 1'b0;
      chip_if.en_2MHz   <= 1'b0;
      chip_if.mem_state <= 1'b0;
      done              <= 1'b0;
      underrun          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            remaining <= nb_chips;
            underrun  <= 1'b0;
            state     <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (take_first) begin
            chip_if.b_in      <= chip_if.chip_data;
            chip_if.en_2MHz   <= 1'b1;
            chip_if.mem_state <= 1'b1;
            div_cnt           <= '0;
            state             <= CHIP;
          end
        end
        CHIP: begin
          // dac_ready low freezes the whole chip period, outputs included.
          if (chip_if.dac_ready) begin
            if (div_cnt != DIV_LAST) begin
              div_cnt         <= div_nxt;
              chip_if.en_2MHz <= (div_nxt < EN_LIM);
            end else if (last_chip) begin
              chip_if.en_2MHz   <= 1'b0;
              chip_if.mem_state <= 1'b0;
              tail_cnt          <= '0;
              state             <= TAIL;
            end else if (chip_if.chip_valid) begin
              chip_if.b_in    <= chip_if.chip_data;
              chip_if.en_2MHz <= 1'b1;
              div_cnt         <= '0;
              remaining       <= remaining - LEN_W'(1);
            end else begin
              underrun        <= 1'b1;
              chip_if.en_2MHz <= 1'b0;
            end
          end
        end
        TAIL: begin
          if (chip_if.dac_ready) begin
            if (tail_cnt == TAIL_LAST) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              tail_cnt <= tail_cnt + TAIL_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CODIQ_SEQ_STATUS_EN
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      chip_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (take_first || take_next) chip_cnt <= chip_cnt + LEN_W'(1);
      if (busy && (!chip_if.dac_ready || starved) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_codiq_sequencer.sv
// Scoreboard bench for codiq_sequencer: stimulus queues expected chips/frames,
// a negedge monitor pops and compares against what the DUT presents.
module tb_codiq_sequencer;
  localparam int CHIP_DIV    = 25;
  localparam int EN_HIGH     = 13;
  localparam int TAIL_CYCLES = 50;
  localparam int LEN_W       = 16;

  typedef struct {
    int   n;
    int   cycles;
    int   extra;
    logic ur;
  } frame_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] nb_chips;
  logic             busy, done, underrun;
`ifdef CODIQ_SEQ_STATUS_EN
  logic [LEN_W-1:0] chip_cnt;
  logic [15:0]      stall_cnt;
`endif

  codiq_sequencer_if sif ();

  codiq_sequencer #(
    .CHIP_DIV(CHIP_DIV), .EN_HIGH(EN_HIGH), .TAIL_CYCLES(TAIL_CYCLES), .LEN_W(LEN_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .nb_chips (nb_chips),
    .chip_if  (sif),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
`ifdef CODIQ_SEQ_STATUS_EN
    ,
    .chip_cnt (chip_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Behavioural first-word-fall-through chip FIFO
  logic       fifo_mem [256];
  logic [7:0] wr_ptr = '0;
  logic [7:0] rd_ptr = '0;
  logic       fifo_flush = 1'b0;

  assign sif.chip_valid = (wr_ptr != rd_ptr);
  assign sif.chip_data  = fifo_mem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (sif.chip_rd && sif.chip_valid) rd_ptr <= rd_ptr + 8'd1;
  end

  task automatic push_chip(input logic b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // Scoreboard queues
  logic   exp_chips[$];
  frame_t exp_frames[$];
  logic   late_chips[$];

  // Monitor state
  int   busy_cyc = 0, stall_cyc = 0, dac_low_cyc = 0, en_hi = 0;
  int   rd_total = 0, done_total = 0;
  logic rd_seen = 1'b0, en_prev = 1'b0, reset_prev = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      busy_cyc = 0; stall_cyc = 0; dac_low_cyc = 0; en_hi = 0; rd_seen = 1'b0;
    end else begin
      if (busy) begin
        busy_cyc++;
        if (!sif.dac_ready) begin
          stall_cyc++;
          dac_low_cyc++;
        end else if (!rd_seen && !(sif.coder_ready && sif.chip_valid)) begin
          stall_cyc++;
        end
      end
      if (sif.chip_rd) begin
        rd_total++;
        rd_seen = 1'b1;
        check("chip_rd_qualified", {30'd0, sif.chip_valid, sif.dac_ready}, 32'd3);
      end
      if (sif.en_2MHz && !en_prev) begin
        en_hi = 0;
        if (exp_chips.size() == 0) fail_now("unexpected_chip");
        else check("b_in", sif.b_in, exp_chips.pop_front());
        check("mem_state_during_chip", sif.mem_state, 1);
      end
      if (sif.en_2MHz && sif.dac_ready) en_hi++;
      if (!sif.en_2MHz && en_prev && !reset_prev) check("en_high_cycles", en_hi, EN_HIGH);
      if (done) begin
        done_total++;
        if (exp_frames.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          frame_t f;
          f = exp_frames.pop_front();
          check("frame_cycles_net_of_stalls", busy_cyc + 1 - stall_cyc, f.cycles);
          check("underrun_flag", underrun, f.ur);
          check("chips_left_at_done", exp_chips.size(), 0);
`ifdef CODIQ_SEQ_STATUS_EN
          check("chip_cnt", chip_cnt, f.n);
          check("stall_cnt", stall_cnt, dac_low_cyc + f.extra);
`endif
        end
        busy_cyc = 0; stall_cyc = 0; dac_low_cyc = 0; rd_seen = 1'b0;
      end
    end
    en_prev    = sif.en_2MHz;
    reset_prev = reset;
  end

  // Queues a frame: chip pattern goes to the scoreboard, first `preload` chips to the FIFO.
  task automatic begin_frame(input int n, input logic [15:0] pattern, input int preload,
                             input int extra, input logic ur);
    frame_t f;
    for (int i = 0; i < n; i++) begin
      exp_chips.push_back(pattern[i]);
      if (i < preload) push_chip(pattern[i]);
      else late_chips.push_back(pattern[i]);
    end
    f.n = n;
    f.cycles = 2 + n * CHIP_DIV + TAIL_CYCLES + extra;
    f.extra = extra;
    f.ur = ur;
    exp_frames.push_back(f);
    start = 1'b1;
    nb_chips = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: readies high, 1: random readies, 2: dac_ready low for cycles [lo,hi)
  task automatic run_frame(input int mode, input int lo, input int hi, input int late_c,
                           input int busy_start_c, output int done_c);
    done_c = 0;
    for (int c = 1; c < 3000; c++) begin
      case (mode)
        1:       begin sif.dac_ready = ($urandom_range(0, 5) != 0);
                       sif.coder_ready = ($urandom_range(0, 3) != 0); end
        2:       begin sif.dac_ready = !(c >= lo && c < hi); sif.coder_ready = 1'b1; end
        default: begin sif.dac_ready = 1'b1; sif.coder_ready = 1'b1; end
      endcase
      if (c == late_c)
        while (late_chips.size() != 0) push_chip(late_chips.pop_front());
      start = (c == busy_start_c);
      if (start) nb_chips = LEN_W'(7);
      @(posedge clk); #1;
      if (done) begin
        done_c = c + 1;
        break;
      end
    end
    if (done_c == 0) fail_now("frame_timeout");
    sif.dac_ready = 1'b1;
    sif.coder_ready = 1'b1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int dc;
  int rd_snap, done_snap;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    nb_chips = '0;
    sif.dac_ready = 1'b1;
    sif.coder_ready = 1'b1;
    idle(3);
    check("reset_outputs",
          {25'd0, sif.chip_rd, sif.b_in, sif.en_2MHz, sif.mem_state, busy, done, underrun}, 0);
    reset = 1'b0;
    idle(2);

    // Directed 4-chip frame 1,0,1,1
    rd_snap = rd_total;
    begin_frame(4, 16'b1101, 4, 0, 1'b0);
    run_frame(0, 0, 0, -1, -1, dc);
    check("frame4_start_to_done", dc, 152);
    check("frame4_chip_rd_count", rd_total - rd_snap, 4);
    idle(3);

    // 43-cycle DAC stall inside chip 2
    begin_frame(4, 16'($urandom), 4, 0, 1'b0);
    run_frame(2, 35, 78, -1, -1, dc);
    check("dac_stall_start_to_done", dc, 152 + 43);
    idle(3);

    // Underrun: third chip written 10 cycles after its boundary
    begin_frame(3, 16'b101, 2, 10, 1'b1);
    run_frame(0, 0, 0, 61, -1, dc);
    check("underrun_start_to_done", dc, 127 + 10);
    check("underrun_sticky_after_done", underrun, 1);
    idle(3);

    // start while busy is ignored
    begin_frame(2, 16'($urandom), 2, 0, 1'b0);
    run_frame(0, 0, 0, -1, 40, dc);
    check("busy_start_frame_len", dc, 2 + 2 * CHIP_DIV + TAIL_CYCLES);
    idle(30);
    check("no_frame_after_busy_start", busy, 0);

    // start with nb_chips = 0 is ignored
    rd_snap = rd_total;
    done_snap = done_total;
    push_chip(1'b1);
    start = 1'b1;
    nb_chips = '0;
    idle(1);
    start = 1'b0;
    idle(40);
    check("zero_len_busy", busy, 0);
    check("zero_len_no_chip_rd", rd_total - rd_snap, 0);
    check("zero_len_no_done", done_total - done_snap, 0);
    fifo_flush = 1'b1;
    idle(1);
    fifo_flush = 1'b0;

    // Reset at chip 2, cycle 7, then a clean frame
    done_snap = done_total;
    begin_frame(4, 16'($urandom), 4, 0, 1'b0);
    idle(33);
    reset = 1'b1;
    idle(1);
    check("mid_frame_reset_outputs",
          {25'd0, sif.chip_rd, sif.b_in, sif.en_2MHz, sif.mem_state, busy, done, underrun}, 0);
    reset = 1'b0;
    fifo_flush = 1'b1;
    exp_chips.delete();
    exp_frames.delete();
    late_chips.delete();
    idle(1);
    fifo_flush = 1'b0;
    idle(5);
    check("no_done_after_reset", done_total - done_snap, 0);
    begin_frame(3, 16'($urandom), 3, 0, 1'b0);
    run_frame(0, 0, 0, -1, -1, dc);
    check("post_reset_frame_len", dc, 127);
    idle(3);

    // Five chips with 43 stall cycles
    begin_frame(5, 16'($urandom), 5, 0, 1'b0);
    run_frame(2, 35, 78, -1, -1, dc);
    check("status_frame_start_to_done", dc, 1 + 5 * CHIP_DIV + TAIL_CYCLES + 1 + 43);
    idle(5);
`ifdef CODIQ_SEQ_STATUS_EN
    check("chip_cnt_holds_after_done", chip_cnt, 5);
    check("stall_cnt_holds_after_done", stall_cnt, 43);
`endif

    // Randomized frames with random readies
    for (int k = 0; k < 10; k++) begin
      begin_frame($urandom_range(1, 6), 16'($urandom), 16, 0, 1'b0);
      run_frame(1, 0, 0, -1, -1, dc);
      idle($urandom_range(1, 4));
    end

    idle(5);
    check("all_frames_completed", exp_frames.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/codiq_sequencer.md
# codiq_sequencer

Frame-level controller for the IQ coder (O-QPSK half-sine modulator) in the Zigbee transmit chain. It pulls chips from an upstream first-word-fall-through chip FIFO. It paces them into the coder at the 2 MHz chip rate derived from the 50 MHz system clock, and drives the coder's `b_in`, `en_2MHz` and `mem_state`. It freezes pacing while the DAC is not ready, then holds a flush window after the last chip so the coder can finish its final half-sine.

## Interface
Parameters:
- `CHIP_DIV`, 25: clock cycles per chip period (50 MHz / 2 MHz).
- `EN_HIGH`, 13: cycles `en_2MHz` stays high at the start of each chip period; valid range 1..`CHIP_DIV`-1.
- `TAIL_CYCLES`, 50: flush window after the last chip, two chip periods.
- `LEN_W`, 16: width of the chip-count field.

Ports:
- `clk`  in  1  system clock, 50 MHz; only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle frame request; sampled only in IDLE.
- `nb_chips`  in  `LEN_W`  frame length in chips; latched on accepted `start`.
- `chip_data`  in  1  FIFO head chip.
- `chip_valid`  in  1  FIFO non-empty.
- `chip_rd`  out  1  one-cycle pop strobe; the head chip is consumed in the same cycle.
- `coder_ready`  in  1  coder's `ready` output.
- `dac_ready`  in  1  DAC accepts samples; low freezes sequencing.
- `b_in`  out  1  chip to the coder.
- `en_2MHz`  out  1  chip strobe to the coder.
- `mem_state`  out  1  frame-active indication to the coder.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at end of frame.
- `underrun`  out  1  sticky flag: FIFO was empty at a chip boundary; cleared by an accepted `start` or by `reset`.

## Operation
- States: IDLE, WAIT_RDY, CHIP, TAIL.
- IDLE:
  - `start`=1 and `nb_chips`≠0: latch `remaining`=`nb_chips`, clear `underrun`, go to WAIT_RDY.
  - `start` with `nb_chips`=0 is ignored.
  - `start` in any other state is ignored.
- WAIT_RDY, when `coder_ready` & `dac_ready` & `chip_valid`:
  - assert `chip_rd`, register `b_in`←`chip_data`;
  - set `div_cnt`=0 and `mem_state`=1;
  - go to CHIP.
- CHIP:
  - When `dac_ready`=1, `div_cnt` increments each cycle.
  - When `dac_ready`=0, `div_cnt`, `b_in`, `en_2MHz` and `mem_state` all hold.
  - `en_2MHz` is registered and is 1 exactly while `div_cnt` < `EN_HIGH`.
- Chip boundary (`div_cnt`=`CHIP_DIV`-1 with `dac_ready`=1):
  - If `remaining`>1 and `chip_valid`: pulse `chip_rd`, load `b_in`, set `div_cnt`=0, decrement `remaining`.
  - If `remaining`>1 and `chip_valid`=0: set `underrun`, hold `div_cnt` at `CHIP_DIV`-1 with `en_2MHz`=0 and `mem_state`=1, and retry every cycle.
  - If `remaining`=1: go to TAIL with `mem_state`=0 and `en_2MHz`=0.
- TAIL: count `TAIL_CYCLES` cycles (count frozen while `dac_ready`=0), then pulse `done` and go to IDLE.
- `coder_ready` is checked only in WAIT_RDY.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-frame: at the next edge every output is 0 and the state is IDLE; no `done` pulse is issued. The FIFO is not flushed.

## Timing
- Latency from accepted `start` to the first `chip_rd` is 1 cycle minimum (the WAIT_RDY cycle).
- `b_in`, `en_2MHz` and `mem_state` rise 1 cycle after `chip_rd`.
- Steady state: one `chip_rd` every `CHIP_DIV` cycles, giving a 2 MHz chip rate.
- `en_2MHz` duty cycle is `EN_HIGH`/`CHIP_DIV`.
- Total frame length without stalls: 1 + N·`CHIP_DIV` + `TAIL_CYCLES` + 1 cycles from `start` to `done`.
- Every `dac_ready` low cycle adds exactly one cycle to the frame.
- `chip_rd` is never asserted while `chip_valid`=0 or `dac_ready`=0.

## Configuration
- `CODIQ_SEQ_STATUS_EN` defined: adds two outputs.
  - `chip_cnt` [`LEN_W`-1:0]: chips sent in the current frame.
  - `stall_cnt` [15:0]: cycles with `dac_ready`=0 or underrun while `busy`; saturates at 0xFFFF.
  - Both counters clear on accepted `start` and on `reset`, and hold after `done`.
- Not defined: neither port nor its logic exists; all other behaviour is identical.

## Test plan
- `nb_chips`=4, FIFO preloaded with 1,0,1,1, all readies high → exactly 4 `chip_rd` pulses spaced 25 cycles; `b_in` sequence 1,0,1,1; each chip has `en_2MHz` high for 13 cycles; `done` arrives 152 cycles after `start`.
- `dac_ready` low for 43 cycles during chip 2 → `div_cnt` and outputs frozen; `done` arrives 43 cycles late; `underrun`=0.
- FIFO holds only 2 of 3 chips, with the third written 10 cycles after the boundary → `underrun`=1, `en_2MHz`=0 for 10 cycles, third chip sent, `done` still pulses.
- `reset` asserted at chip 2, cycle 7 → next edge all outputs 0 and state IDLE; a new `start` then runs a clean frame.
- `start` with `nb_chips`=0, and `start` while `busy` → both ignored; no `chip_rd`, no `done`.
- With `CODIQ_SEQ_STATUS_EN`, `nb_chips`=5 and 43 stall cycles → `chip_cnt`=5 and `stall_cnt`=43 after `done`.
